// File: rtl/day_10_solver_scheduler.sv
// Day 10 machine scheduler: hands machine indices round-robin to a pool of solver
// engines, collects their minimum-press counts and accumulates the 64-bit answer.
module day_10_solver_scheduler #(
  parameter int TOTAL_MACHINES = 3,
  parameter int NUM_ENGINES    = 2,
  parameter int IDX_W          = 8,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [NUM_ENGINES-1:0]            eng_start,
  output logic [NUM_ENGINES*IDX_W-1:0]      eng_machine,
  input  logic [NUM_ENGINES-1:0]            eng_done,
  input  logic [NUM_ENGINES*DATA_WIDTH-1:0] eng_presses,
  output logic                              busy,
  output logic                              finished,
  output logic [63:0]                       result,
  output logic [15:0]                       unsolved_count,
  output logic [1:0]                        dbg_state
);

  localparam int RR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int NM_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [NM_W-1:0]                next_machine_q, next_machine_d;
  logic [RR_W-1:0]                rr_q, rr_d, rr_pick;
  logic [NUM_ENGINES-1:0]         eng_busy_q, eng_busy_d;
  logic [NUM_ENGINES-1:0]         eng_start_q, eng_start_d;
  logic [NUM_ENGINES*IDX_W-1:0]   eng_machine_q, eng_machine_d;
  logic [63:0]                    result_q, result_d, sum_inc;
  logic [15:0]                    unsolved_q, unsolved_d, unsolved_inc;
  logic [16:0]                    unsolved_sum;
  logic [NUM_ENGINES-1:0]         accepted, pick_oh;
  logic [DATA_WIDTH-1:0]          presses;
  logic                           found;

  always_comb begin
    state_d        = state_q;
    next_machine_d = next_machine_q;
    rr_d           = rr_q;
    eng_machine_d  = eng_machine_q;
    eng_start_d    = '0;

    // A done only counts for an engine we actually launched.
    accepted = '0;
    if (state_q == S_RUN || state_q == S_DRAIN) accepted = eng_done & eng_busy_q;

    sum_inc      = '0;
    unsolved_inc = '0;
    presses      = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      presses = eng_presses[e*DATA_WIDTH +: DATA_WIDTH];
      if (accepted[e]) begin
        if (presses == {DATA_WIDTH{1'b1}}) unsolved_inc = unsolved_inc + 16'd1;
        else                               sum_inc = sum_inc + 64'(presses);
      end
    end
    unsolved_sum = {1'b0, unsolved_q} + {1'b0, unsolved_inc};
    result_d     = result_q + sum_inc;
    unsolved_d   = unsolved_sum[16] ? 16'hFFFF : unsolved_sum[15:0];
    eng_busy_d   = eng_busy_q & ~accepted;

    // First idle engine at or after rr, then wrap to the low indices.
    found   = 1'b0;
    pick_oh = '0;
    rr_pick = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      if (!found && !eng_busy_q[e] && e >= int'(rr_q)) begin
        found      = 1'b1;
        pick_oh[e] = 1'b1;
        rr_pick    = (e == NUM_ENGINES - 1) ? '0 : RR_W'(e + 1);
      end
    end
    for (int e = 0; e < NUM_ENGINES; e++) begin
      if (!found && !eng_busy_q[e]) begin
        found      = 1'b1;
        pick_oh[e] = 1'b1;
        rr_pick    = (e == NUM_ENGINES - 1) ? '0 : RR_W'(e + 1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          result_d       = '0;
          unsolved_d     = '0;
          next_machine_d = '0;
          rr_d           = '0;
          eng_busy_d     = '0;
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        if (next_machine_q < NM_W'(TOTAL_MACHINES) && found) begin
          eng_start_d    = pick_oh;
          eng_busy_d     = eng_busy_d | pick_oh;
          next_machine_d = next_machine_q + NM_W'(1);
          rr_d           = rr_pick;
          for (int e = 0; e < NUM_ENGINES; e++) begin
            if (pick_oh[e]) eng_machine_d[e*IDX_W +: IDX_W] = next_machine_q[IDX_W-1:0];
          end
          if (next_machine_q == NM_W'(TOTAL_MACHINES - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (eng_busy_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      next_machine_q <= '0;
      rr_q           <= '0;
      eng_busy_q     <= '0;
      eng_start_q    <= '0;
      eng_machine_q  <= '0;
      result_q       <= '0;
      unsolved_q     <= '0;
    end else begin
      state_q        <= state_d;
      next_machine_q <= next_machine_d;
      rr_q           <= rr_d;
      eng_busy_q     <= eng_busy_d;
      eng_start_q    <= eng_start_d;
      eng_machine_q  <= eng_machine_d;
      result_q       <= result_d;
      unsolved_q     <= unsolved_d;
    end
  end

  assign eng_start      = eng_start_q;
  assign eng_machine    = eng_machine_q;
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign finished       = (state_q == S_DONE);
  assign result         = result_q;
  assign unsolved_count = unsolved_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_day_10_solver_scheduler.sv
// Directed bench for day_10_solver_scheduler: a single-engine instance and a
// two-engine instance, both solving three machines.
module tb_day_10_solver_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;

  logic [0:0]  eng_start1, eng_done1;
  logic [7:0]  eng_machine1;
  logic [31:0] eng_presses1;
  logic        busy1, finished1;
  logic [63:0] result1;
  logic [15:0] unsolved1;
  logic [1:0]  state1;

  logic [1:0]  eng_start2, eng_done2;
  logic [15:0] eng_machine2;
  logic [63:0] eng_presses2;
  logic        busy2, finished2;
  logic [63:0] result2;
  logic [15:0] unsolved2;
  logic [1:0]  state2;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses1  = 0;
  int pulses2  = 0;
  int p0, fw;

  always #5 clk = ~clk;

  day_10_solver_scheduler #(.TOTAL_MACHINES(3), .NUM_ENGINES(1), .IDX_W(8), .DATA_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .eng_start(eng_start1), .eng_machine(eng_machine1),
    .eng_done(eng_done1), .eng_presses(eng_presses1),
    .busy(busy1), .finished(finished1), .result(result1),
    .unsolved_count(unsolved1), .dbg_state(state1)
  );

  day_10_solver_scheduler #(.TOTAL_MACHINES(3), .NUM_ENGINES(2), .IDX_W(8), .DATA_WIDTH(32)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .eng_start(eng_start2), .eng_machine(eng_machine2),
    .eng_done(eng_done2), .eng_presses(eng_presses2),
    .busy(busy2), .finished(finished2), .result(result2),
    .unsolved_count(unsolved2), .dbg_state(state2)
  );

  always @(posedge clk) begin
    #2;
    pulses1 += int'(eng_start1[0]);
    pulses2 += $countones(eng_start2);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-engine model: waits for each launch, answers a few cycles later.
  task automatic serve1(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                        output int first_wait);
    logic [31:0] res [3];
    res[0] = r0; res[1] = r1; res[2] = r2;
    first_wait = 0;
    for (int m = 0; m < 3; m++) begin
      int   waited;
      logic seen;
      waited = 0;
      seen   = eng_start1[0];
      while (!seen && waited < 40) begin
        @(negedge clk);
        waited++;
        seen = eng_start1[0];
      end
      if (m == 0) first_wait = waited;
      chk("d1_dispatch_seen", 64'(seen), 64'd1);
      chk("d1_machine", 64'(eng_machine1), 64'(m));
      repeat (4) @(negedge clk);
      eng_done1 = 1'b1; eng_presses1 = res[m];
      @(negedge clk);
      eng_done1 = 1'b0; eng_presses1 = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    eng_done1 = '0; eng_presses1 = '0;
    eng_done2 = '0; eng_presses2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_d1_ctrl", {eng_start1, eng_machine1, busy1, finished1, unsolved1, state1}, 64'd0);
    chk("rst_d1_result", result1, 64'd0);
    chk("rst_d2_ctrl", {eng_start2, eng_machine2, busy2, finished2, unsolved2, state2}, 64'd0);
    chk("rst_d2_result", result2, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single engine: 10 + 12 + 11.
    p0 = pulses1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("d1_busy_after_start", 64'(busy1), 64'd1);
    chk("d1_no_early_start", 64'(eng_start1), 64'd0);
    serve1(32'd10, 32'd12, 32'd11, fw);
    chk("d1_latency", 64'(fw), 64'd1);
    chk("d1_finished", 64'(finished1), 64'd1);
    chk("d1_result", result1, 64'd33);
    chk("d1_unsolved", 64'(unsolved1), 64'd0);
    chk("d1_busy_done", 64'(busy1), 64'd0);
    repeat (3) @(negedge clk);
    chk("d1_pulse_count", 64'(pulses1 - p0), 64'd3);
    chk("d1_result_hold", result1, 64'd33);

    // Rerun from DONE.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("d1_rerun_fin_drop", 64'(finished1), 64'd0);
    chk("d1_rerun_clear", result1, 64'd0);
    serve1(32'd10, 32'd12, 32'd11, fw);
    chk("d1_rerun_finished", 64'(finished1), 64'd1);
    chk("d1_rerun_result", result1, 64'd33);

    // Two engines: same-cycle dones 7 and 9, then machine 2 returns 4.
    p0 = pulses2;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("d2a_n1_start", 64'(eng_start2), 64'd0);
    @(negedge clk);
    chk("d2a_n2_start", 64'(eng_start2), 64'b01);
    chk("d2a_n2_mach0", 64'(eng_machine2[7:0]), 64'd0);
    @(negedge clk);
    chk("d2a_n3_start", 64'(eng_start2), 64'b10);
    chk("d2a_n3_mach1", 64'(eng_machine2[15:8]), 64'd1);
    @(negedge clk);
    chk("d2a_n4_start", 64'(eng_start2), 64'd0);
    chk("d2a_n4_state", 64'(state2), 64'd1);
    eng_done2 = 2'b11; eng_presses2 = {32'd9, 32'd7};
    @(negedge clk);
    eng_done2 = 2'b00; eng_presses2 = '0;
    chk("d2a_no_same_cycle_reuse", 64'(eng_start2), 64'd0);
    chk("d2a_dual_sum", result2, 64'd16);
    @(negedge clk);
    chk("d2a_redispatch_e0", 64'(eng_start2), 64'b01);
    chk("d2a_mach2_e0", 64'(eng_machine2[7:0]), 64'd2);
    chk("d2a_e1_hold", 64'(eng_machine2[15:8]), 64'd1);
    chk("d2a_drain", 64'(state2), 64'd2);
    repeat (3) @(negedge clk);
    eng_done2 = 2'b01; eng_presses2 = {32'd0, 32'd4};
    @(negedge clk);
    eng_done2 = 2'b00; eng_presses2 = '0;
    chk("d2a_finished", 64'(finished2), 64'd1);
    chk("d2a_result", result2, 64'd20);
    chk("d2a_unsolved", 64'(unsolved2), 64'd0);
    chk("d2a_busy", 64'(busy2), 64'd0);
    chk("d2a_pulses", 64'(pulses2 - p0), 64'd3);

    // Unsolved machine, spurious dones on idle engines, start while busy.
    p0 = pulses2;
    start2 = 1'b1;
    @(negedge clk);
    chk("d2b_fin_drop", 64'(finished2), 64'd0);
    chk("d2b_clear", result2, 64'd0);
    eng_done2 = 2'b11; eng_presses2 = {32'd100, 32'd100};
    @(negedge clk);
    start2 = 1'b0; eng_done2 = 2'b00; eng_presses2 = '0;
    chk("d2b_start_e0", 64'(eng_start2), 64'b01);
    chk("d2b_spurious_ignored", result2, 64'd0);
    @(negedge clk);
    chk("d2b_start_e1", 64'(eng_start2), 64'b10);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("d2b_no_restart", 64'(eng_start2), 64'd0);
    chk("d2b_busy", 64'(busy2), 64'd1);
    eng_done2 = 2'b10; eng_presses2 = {32'hFFFF_FFFF, 32'd0};
    @(negedge clk);
    eng_done2 = 2'b00; eng_presses2 = '0;
    chk("d2b_unsolved1", 64'(unsolved2), 64'd1);
    chk("d2b_unsolved_no_sum", result2, 64'd0);
    @(negedge clk);
    chk("d2b_mach2_e1", 64'(eng_start2), 64'b10);
    chk("d2b_mach2_idx", 64'(eng_machine2[15:8]), 64'd2);
    chk("d2b_drain", 64'(state2), 64'd2);
    eng_done2 = 2'b01; eng_presses2 = {32'd0, 32'd5};
    @(negedge clk);
    eng_done2 = 2'b00; eng_presses2 = '0;
    chk("d2b_not_finished", 64'(finished2), 64'd0);
    chk("d2b_partial", result2, 64'd5);
    eng_done2 = 2'b10; eng_presses2 = {32'd6, 32'd0};
    @(negedge clk);
    eng_done2 = 2'b00; eng_presses2 = '0;
    chk("d2b_finished", 64'(finished2), 64'd1);
    chk("d2b_result", result2, 64'd11);
    chk("d2b_unsolved", 64'(unsolved2), 64'd1);
    repeat (2) @(negedge clk);
    chk("d2b_pulses", 64'(pulses2 - p0), 64'd3);

    // Reset mid-run with a late done still to come.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("d1r_first_dispatch", 64'(eng_start1), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("d1r_ctrl", {eng_start1, eng_machine1, busy1, finished1, unsolved1, state1}, 64'd0);
    chk("d1r_result", result1, 64'd0);
    chk("d2r_result", result2, 64'd0);
    eng_done1 = 1'b1; eng_presses1 = 32'd10;
    @(negedge clk);
    eng_done1 = 1'b0; eng_presses1 = '0;
    chk("d1r_late_done_ignored", result1, 64'd0);
    chk("d1r_idle", 64'(state1), 64'd0);
    chk("d1r_no_start", 64'(eng_start1), 64'd0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    serve1(32'd10, 32'd12, 32'd11, fw);
    chk("d1r_latency", 64'(fw), 64'd1);
    chk("d1r_finished", 64'(finished1), 64'd1);
    chk("d1r_result_full", result1, 64'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
